// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side capture inputs plus the register-file write port.
// master drives the MEM-side signals, slave is the stage itself.
interface mem_wb_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     stall;
  logic                     flush;
  logic                     in_valid;
  logic                     in_reg_wrt;
  logic [ADDRESS_WIDTH-1:0] in_rd_addr;
  logic [1:0]               in_wb_sel;
  logic [2:0]               in_funct3;
  logic [DATA_WIDTH-1:0]    in_alu_result;
  logic [DATA_WIDTH-1:0]    in_pc_plus4;
  logic [DATA_WIDTH-1:0]    in_mem_rdata;
  logic                     rg_wrt_en;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
  logic [DATA_WIDTH-1:0]    rg_wrt_data;
  logic                     wb_valid;
  logic                     misalign_err;

  modport master (
    output stall, flush, in_valid, in_reg_wrt, in_rd_addr, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, in_mem_rdata,
    input  rg_wrt_en, rg_wrt_dest, rg_wrt_data, wb_valid, misalign_err
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_wrt, in_rd_addr, in_wb_sel, in_funct3,
           in_alu_result, in_pc_plus4, in_mem_rdata,
    output rg_wrt_en, rg_wrt_dest, rg_wrt_data, wb_valid, misalign_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, writeback select, registered regfile write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  mem_wb_stage_if.slave bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_count
`endif
);

  logic [1:0]               w_off;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load;
  logic                     w_misalign;
  logic [DATA_WIDTH-1:0]    w_wb_data;
  logic                     w_wen;

  logic                     r_valid;
  logic                     r_wen;
  logic [ADDRESS_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_misalign;

  assign w_off  = bus.in_alu_result[1:0];
  assign w_byte = bus.in_mem_rdata[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];

  // funct3[1:0]: 00 byte, 01 half, 1x full word; funct3[2] selects zero-extension
  always_comb begin
    w_load     = bus.in_mem_rdata;
    w_misalign = 1'b0;
    case (bus.in_funct3[1:0])
      2'b00: w_load = bus.in_funct3[2] ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                       : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      2'b01: begin
        w_load     = bus.in_funct3[2] ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                      : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        w_misalign = w_off[0];
      end
      default: w_misalign = (w_off != 2'b00);
    endcase
  end

  always_comb begin
    w_wb_data = bus.in_alu_result;
    case (bus.in_wb_sel)
      2'b01:   w_wb_data = w_load;
      2'b10:   w_wb_data = bus.in_pc_plus4;
      default: w_wb_data = bus.in_alu_result;
    endcase
  end

  logic w_is_misalign;
  assign w_is_misalign = bus.in_valid & (bus.in_wb_sel == 2'b01) & w_misalign;
  assign w_wen = bus.in_valid & bus.in_reg_wrt & (bus.in_rd_addr != '0) & ~w_is_misalign;

  // flush beats stall; data/dest keep stale values on a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wen      <= 1'b0;
      r_dest     <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_wen      <= 1'b0;
      r_misalign <= 1'b0;
    end else if (!bus.stall) begin
      r_valid    <= bus.in_valid;
      r_wen      <= w_wen;
      r_dest     <= bus.in_rd_addr;
      r_data     <= w_wb_data;
      r_misalign <= w_is_misalign;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_retire <= '0;
    else if (r_valid && (!bus.stall || bus.flush))
      r_retire <= r_retire + 64'd1;
  end
  assign retire_count = r_retire;
`endif

  assign bus.rg_wrt_en    = r_wen;
  assign bus.rg_wrt_dest  = r_dest;
  assign bus.rg_wrt_data  = r_data;
  assign bus.wb_valid     = r_valid;
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a negedge-write register file model.
module tb_mem_wb_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] rf [32];

  mem_wb_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) ifc ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
  mem_wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .retire_count(retire_count));
`else
  mem_wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (ifc.rg_wrt_en) rf[ifc.rg_wrt_dest] <= ifc.rg_wrt_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] rdata);
    ifc.in_valid      = v;
    ifc.in_reg_wrt    = rw;
    ifc.in_rd_addr    = rd;
    ifc.in_wb_sel     = sel;
    ifc.in_funct3     = f3;
    ifc.in_alu_result = alu;
    ifc.in_pc_plus4   = pc;
    ifc.in_mem_rdata  = rdata;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic en,
                         input logic [4:0] rd, input logic [31:0] d, input logic mis);
    chk({tag, ".valid"}, 64'(ifc.wb_valid), 64'(v));
    chk({tag, ".en"},    64'(ifc.rg_wrt_en), 64'(en));
    if (en) begin
      chk({tag, ".dest"}, 64'(ifc.rg_wrt_dest), 64'(rd));
      chk({tag, ".data"}, 64'(ifc.rg_wrt_data), 64'(d));
    end
    chk({tag, ".mis"},   64'(ifc.misalign_err), 64'(mis));
  endtask

  localparam logic [31:0] RD = 32'h80F0_7F81;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b0;
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    drive(1, 1, 5'd9, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step; step;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.data", 64'(ifc.rg_wrt_data), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU writeback and regfile landing at the following negedge
    drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    step;
    chk_out("alu", 1, 1, 5'd5, 32'h0000_1234, 0);
    @(negedge clk); #1;
    chk("rf.x5", 64'(rf[5]), 64'h1234);

    drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1003, 32'h0, RD); step;
    chk_out("lb3", 1, 1, 5'd6, 32'hFFFF_FF80, 0);
    drive(1, 1, 5'd6, 2'b01, 3'b100, 32'h0000_1001, 32'h0, RD); step;
    chk_out("lbu1", 1, 1, 5'd6, 32'h0000_007F, 0);
    drive(1, 1, 5'd6, 2'b01, 3'b001, 32'h0000_1002, 32'h0, RD); step;
    chk_out("lh2", 1, 1, 5'd6, 32'hFFFF_80F0, 0);
    drive(1, 1, 5'd6, 2'b01, 3'b101, 32'h0000_1000, 32'h0, RD); step;
    chk_out("lhu0", 1, 1, 5'd6, 32'h0000_7F81, 0);
    drive(1, 1, 5'd6, 2'b01, 3'b010, 32'h0000_1000, 32'h0, RD); step;
    chk_out("lw0", 1, 1, 5'd6, 32'h80F0_7F81, 0);
    drive(1, 1, 5'd6, 2'b01, 3'b000, 32'h0000_1002, 32'h0, RD); step;
    chk_out("lb2", 1, 1, 5'd6, 32'hFFFF_FFF0, 0);

    // misaligned loads: one cycle of misalign_err, write suppressed
    drive(1, 1, 5'd8, 2'b01, 3'b010, 32'h0000_1002, 32'h0, RD); step;
    chk_out("mis.lw", 1, 0, 5'd8, 32'h0, 1);
    drive(1, 1, 5'd8, 2'b00, 3'b000, 32'h0000_0042, 32'h0, RD); step;
    chk_out("mis.clr", 1, 1, 5'd8, 32'h0000_0042, 0);
    drive(1, 1, 5'd8, 2'b01, 3'b001, 32'h0000_1003, 32'h0, RD); step;
    chk_out("mis.lh", 1, 0, 5'd8, 32'h0, 1);

    drive(1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0011, 32'h0000_2004, RD); step;
    chk_out("pc4", 1, 1, 5'd1, 32'h0000_2004, 0);
    drive(1, 1, 5'd2, 2'b11, 3'b000, 32'h0000_0077, 32'h0000_2004, RD); step;
    chk_out("sel11", 1, 1, 5'd2, 32'h0000_0077, 0);
    drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_0055, 32'h0, RD); step;
    chk_out("x0", 1, 0, 5'd0, 32'h0, 0);
    drive(0, 1, 5'd4, 2'b00, 3'b000, 32'h0000_0055, 32'h0, RD); step;
    chk_out("bubble", 0, 0, 5'd4, 32'h0, 0);

    // stall holds rd7/0xAA while inputs change; flush then overrides stall
    drive(1, 1, 5'd7, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, RD); step;
    chk_out("cap7", 1, 1, 5'd7, 32'h0000_00AA, 0);
    ifc.stall = 1'b1;
    drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h0000_0BAD, 32'h0, RD);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_out($sformatf("stall%0d", i), 1, 1, 5'd7, 32'h0000_00AA, 0);
    end
    ifc.flush = 1'b1; step;
    chk_out("flush", 0, 0, 5'd0, 32'h0, 0);
    ifc.flush = 1'b0;
    ifc.stall = 1'b0;

    // a flushed misaligned entry drops its error flag
    drive(1, 1, 5'd8, 2'b01, 3'b010, 32'h0000_1001, 32'h0, RD); step;
    chk_out("mis.pre", 1, 0, 5'd8, 32'h0, 1);
    ifc.flush = 1'b1; step;
    chk_out("mis.flush", 0, 0, 5'd8, 32'h0, 0);
    ifc.flush = 1'b0;

    // asynchronous reset mid-stall with a live write
    drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h0000_0333, 32'h0, RD); step;
    chk_out("pre.rst", 1, 1, 5'd3, 32'h0000_0333, 0);
    ifc.stall = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_out("async.rst", 0, 0, 5'd0, 32'h0, 0);
    chk("async.rst.data", 64'(ifc.rg_wrt_data), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    ifc.stall = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    chk("cnt.rst", retire_count, 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 32'h0, RD);
      step;
      if (i == 4) begin
        ifc.stall = 1'b1;
        step; step;
        ifc.stall = 1'b0;
      end
    end
    drive(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, RD);
    step;
    chk("cnt.10", retire_count, 64'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback stage; sits directly upstream of the register file and drives its write port (rg_wrt_en / rg_wrt_dest / rg_wrt_data).
- Captures MEM-stage results on the rising clk edge.
- Performs load byte/halfword extraction and sign/zero extension.
- Selects the writeback source.
- Outputs are registered, so they are stable at the register file's falling-edge write, half a cycle later.

Parameters:
DATA_WIDTH, 32, datapath width; must be 32 for load alignment logic
ADDRESS_WIDTH, 5, register address width

Ports:
clk  input  1  clock; stage registers update on rising edge
rst  input  1  asynchronous active-low reset; stage cleared while rst==0
stall  input  1  hold current stage contents
flush  input  1  insert bubble instead of capturing MEM inputs
in_valid  input  1  MEM stage holds a real instruction
in_reg_wrt  input  1  instruction writes a register
in_rd_addr  input  ADDRESS_WIDTH  destination register
in_wb_sel  input  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as 00)
in_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
in_alu_result  input  DATA_WIDTH  ALU result / load byte address
in_pc_plus4  input  DATA_WIDTH  return address for JAL/JALR
in_mem_rdata  input  DATA_WIDTH  raw aligned word read from data memory
rg_wrt_en  output  1  register file write enable
rg_wrt_dest  output  ADDRESS_WIDTH  register file write address
rg_wrt_data  output  DATA_WIDTH  register file write data
wb_valid  output  1  stage holds a valid instruction (also used by forwarding)
misalign_err  output  1  held load was misaligned; write suppressed

Behaviour:
- Reset (rst==0, async): wb_valid=0, rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, misalign_err=0; retire_count=0 if compiled in. Takes effect immediately, mid-stall or mid-flush. Release is sampled on the next rising edge.
- Rising-edge capture priority, in order:
  - flush=1: load a bubble. wb_valid=0, rg_wrt_en=0, misalign_err=0. Data/dest registers may hold stale values. Flush overrides stall.
  - stall=1: all registers hold. Outputs are unchanged, so a held write repeats at the next negedge; this is idempotent.
  - otherwise: capture the MEM inputs.
- Latency: 1 cycle MEM->WB. A value captured at posedge N is written into the register file at the negedge inside cycle N.
- Load extraction uses offset = in_alu_result[1:0]:
  - LB/LBU: byte at offset, bits [8*off+7 : 8*off]; sign- or zero-extended to 32.
  - LH/LHU: halfword at offset[1]*16; sign- or zero-extended. Legal only when offset[0]==0.
  - LW and funct3 011/110/111: full word. Legal only when offset==0.
- Misaligned load (in_wb_sel==01 with an illegal offset): captured misalign_err=1 and rg_wrt_en=0. misalign_err stays set only while that entry occupies the stage.
- Write enable: rg_wrt_en = in_valid & in_reg_wrt & (in_rd_addr!=0) & !misalign; evaluated at capture. Writes to x0 are never issued.
- in_valid=0 captures a bubble: wb_valid=0, rg_wrt_en=0.
- rg_wrt_data for bubbles is don't-care, but must not be X after reset.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: adds output retire_count (64 bits).
  - Increments by 1 on each rising edge where wb_valid=1 and (stall=0 or flush=1), i.e. the entry departs the stage.
  - Misaligned entries and x0 writes still count as retired.
  - Wraps from 2^64-1 to 0.
  - Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: drive rst=0 mid-run with rg_wrt_en=1 -> rg_wrt_en, wb_valid, rg_wrt_data all 0 immediately, before the next clk edge.
- ALU writeback: in_valid=1, in_reg_wrt=1, rd=5, wb_sel=00, alu=0x0000_1234 -> next cycle rg_wrt_en=1, dest=5, data=0x0000_1234; regfile x5 reads 0x1234 after the negedge.
- Loads on mem_rdata=0x80F0_7F81:
  - LB off=3 -> 0xFFFF_FF80
  - LBU off=1 -> 0x0000_007F
  - LH off=2 -> 0xFFFF_80F0
  - LHU off=0 -> 0x0000_7F81
  - LW off=0 -> 0x80F0_7F81
- Misalign: LW alu=0x1002 -> rg_wrt_en=0, misalign_err=1 for one cycle. LH alu=0x1003 -> same response.
- Stall/flush: capture rd=7 value 0xAA, then stall=1 for 3 cycles -> outputs held at rd=7/0xAA. Then flush=1 with stall=1 -> wb_valid=0, rg_wrt_en=0 next cycle.
- x0 and counter: rd=0 with reg_wrt=1 -> rg_wrt_en=0. With WB_RETIRE_CNT_EN, 10 valid instructions including 2 stall cycles -> retire_count=10.
